// File: rtl/load_store_unit.sv
// Load/store unit: takes one core load/store request at a time, checks alignment,
// issues a single word-aligned memory access with lane-replicated write data and
// byte strobes, extracts and extends returned load data, and holds the response
// until the core takes it.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   req_*                        core request channel (valid/ready handshake)
//   resp_*                       core response channel (valid/ready handshake)
//   Address, MemWrite, MemRead   memory request, accepted by Mem_Req_Ready
//   Write_data, Write_strb       replicated store data and byte strobes
//   Read_data*                   memory read-return channel (valid/ready handshake)
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic [31:0]           Write_data,
  output logic [3:0]            Write_strb,
  input  logic                  Mem_Req_Ready,
  input  logic [31:0]           Read_data,
  input  logic                  Read_data_Valid,
  output logic                  Read_data_Ready
);

  typedef enum logic [2:0] {StIdle, StWreq, StRreq, StRdw, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    acc_err;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             ld_ext;

  // Illegal size or an address not aligned to the access size.
  assign acc_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Lane extraction and extension of returned load data.
  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: ld_byte = Read_data[7:0];
      2'd1: ld_byte = Read_data[15:8];
      2'd2: ld_byte = Read_data[23:16];
      2'd3: ld_byte = Read_data[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? Read_data[31:16] : Read_data[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = Read_data;
    endcase
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = acc_err;
          if (acc_err)      state_d = StResp;
          else if (req_wen) state_d = StWreq;
          else              state_d = StRreq;
        end
      end
      StWreq: if (Mem_Req_Ready) state_d = StResp;
      StRreq: if (Mem_Req_Ready) state_d = StRdw;
      StRdw: begin
        if (Read_data_Valid) begin
          rdata_d = ld_ext;
          state_d = StResp;
        end
      end
      StResp: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Gating with resetn keeps req_ready low while reset is held.
  assign req_ready       = resetn && (state_q == StIdle);
  assign resp_valid      = (state_q == StResp);
  assign resp_rdata      = rdata_q;
  assign resp_err        = err_q;
  assign Address         = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign MemWrite        = (state_q == StWreq);
  assign MemRead         = (state_q == StRreq);
  assign Read_data_Ready = (state_q == StRdw);

  always_comb begin
    case (size_q)
      2'b00:   Write_data = {4{wdata_q[7:0]}};
      2'b01:   Write_data = {2{wdata_q[15:0]}};
      default: Write_data = wdata_q;
    endcase
    Write_strb = 4'b0000;
    if (state_q == StWreq) begin
      case (size_q)
        2'b00:   Write_strb = 4'b0001 << addr_q[1:0];
        2'b01:   Write_strb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: Write_strb = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests push expected
// responses into a scoreboard; a negedge monitor pops and compares on every
// response handshake and watches hold-stability of memory and response signals.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
  logic [3:0]  Write_strb;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wen         (req_wen),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       mon_e;
  int          checks = 0;
  int          errors = 0;

  // Responder knobs, written by the stimulus process only.
  int          mem_req_delay = 0;
  int          rd_delay      = 0;
  int          resp_delay    = 0;
  logic [31:0] mem_rdata     = 32'h0;

  // Observations, written by the monitor only.
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [31:0] obs_waddr, obs_wdata, obs_raddr;
  logic [3:0]  obs_strb;
  logic        prev_mem_hold = 1'b0;
  logic        prev_resp_hold = 1'b0;
  logic        prev_w, prev_r, prev_err;
  logic [31:0] prev_addr, prev_data, prev_rdata;
  logic [3:0]  prev_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Memory and response-side responder with programmable wait cycles.
  initial begin
    int req_cnt, rd_cnt, rsp_cnt;
    req_cnt = 0;
    rd_cnt  = 0;
    rsp_cnt = 0;
    Mem_Req_Ready   = 1'b0;
    Read_data_Valid = 1'b0;
    Read_data       = 32'h5A5A_5A5A;
    resp_ready      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (MemWrite || MemRead) begin
        Mem_Req_Ready = (req_cnt >= mem_req_delay);
        req_cnt++;
      end else begin
        Mem_Req_Ready = 1'b0;
        req_cnt = 0;
      end
      if (Read_data_Ready) begin
        Read_data_Valid = (rd_cnt >= rd_delay);
        rd_cnt++;
      end else begin
        Read_data_Valid = 1'b0;
        rd_cnt = 0;
      end
      // Garbage on the bus when not valid exposes captures at the wrong time.
      Read_data = Read_data_Valid ? mem_rdata : 32'h5A5A_5A5A;
      if (resp_valid) begin
        resp_ready = (rsp_cnt >= resp_delay);
        rsp_cnt++;
      end else begin
        resp_ready = 1'b0;
        rsp_cnt = 0;
      end
    end
  end

  // Scoreboard and stability monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", 32'(resp_err), 32'(mon_e.err));
        end
      end
      if (prev_resp_hold) begin
        check("resp_valid_held", 32'(resp_valid), 32'd1);
        check("resp_rdata_stable", resp_rdata, prev_rdata);
        check("resp_err_stable", 32'(resp_err), 32'(prev_err));
      end
      prev_resp_hold = resp_valid && !resp_ready;
      prev_rdata     = resp_rdata;
      prev_err       = resp_err;

      if (prev_mem_hold) begin
        check("memwrite_held", 32'(MemWrite), 32'(prev_w));
        check("memread_held", 32'(MemRead), 32'(prev_r));
        check("address_stable", Address, prev_addr);
        check("wdata_stable", Write_data, prev_data);
        check("wstrb_stable", 32'(Write_strb), 32'(prev_strb));
      end
      prev_mem_hold = (MemWrite || MemRead) && !Mem_Req_Ready;
      prev_w        = MemWrite;
      prev_r        = MemRead;
      prev_addr     = Address;
      prev_data     = Write_data;
      prev_strb     = Write_strb;

      if (!MemWrite) check("wstrb_idle_zero", 32'(Write_strb), 32'h0);
      if (MemRead) rd_cycles++;
      if (MemWrite) wr_cycles++;
      if (MemWrite && Mem_Req_Ready) begin
        obs_waddr = Address;
        obs_wdata = Write_data;
        obs_strb  = Write_strb;
      end
      if (MemRead && Mem_Req_Ready) obs_raddr = Address;
    end else begin
      prev_mem_hold  = 1'b0;
      prev_resp_hold = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_memwrite"}, 32'(MemWrite), 32'h0);
    check({tag, "_memread"}, 32'(MemRead), 32'h0);
    check({tag, "_rd_ready"}, 32'(Read_data_Ready), 32'h0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'h0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_address"}, Address, 32'h0);
    check({tag, "_wdata"}, Write_data, 32'h0);
    check({tag, "_wstrb"}, 32'(Write_strb), 32'h0);
  endtask

  // One full transaction: issue, measure accept->resp_valid latency, finish handshake.
  task automatic issue(input string name, input logic wen, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int  lat;
    bit  done;
    exp_q.push_back(resp_t'{rdata: exp_rdata, err: exp_err});
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
    end
    if (!done) fail_now({name, "_accept"});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) done = 1'b1;
    end
    if (!done) fail_now({name, "_handshake"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  rd0, wr0, n, hs_n, acc_n;
    bit  done;
    resetn = 1'b0;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_addr = 32'h0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_wdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;

    issue("st_byte", 1'b1, 32'h103, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 1'b0, 2);
    check("st_byte_addr", obs_waddr, 32'h100);
    check("st_byte_strb", 32'(obs_strb), 32'h8);
    check("st_byte_data", obs_wdata, 32'hABAB_ABAB);

    mem_rdata = 32'h8001_1234;
    issue("ld_half_s", 1'b0, 32'h202, 2'b01, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, 3);
    check("ld_half_s_addr", obs_raddr, 32'h200);
    issue("ld_half_u", 1'b0, 32'h202, 2'b01, 1'b1, 32'h0, 32'h0000_8001, 1'b0, 3);

    rd0 = rd_cycles;
    issue("ld_word_mis", 1'b0, 32'h301, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    check("ld_word_mis_no_read", 32'(rd_cycles), 32'(rd0));
    issue("ld_size3", 1'b0, 32'h0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    wr0 = wr_cycles;
    issue("st_half_mis", 1'b1, 32'h1, 2'b01, 1'b0, 32'h1234, 32'h0, 1'b1, 1);
    check("st_half_mis_no_write", 32'(wr_cycles), 32'(wr0));

    mem_rdata = 32'h0000_8000;
    issue("ld_byte_s", 1'b0, 32'h1, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    mem_rdata = 32'hF700_0000;
    issue("ld_byte_u", 1'b0, 32'h7, 2'b00, 1'b1, 32'h0, 32'h0000_00F7, 1'b0, 3);
    mem_rdata = 32'h0000_7FFF;
    issue("ld_half_pos", 1'b0, 32'h0, 2'b01, 1'b0, 32'h0, 32'h0000_7FFF, 1'b0, 3);
    mem_rdata = 32'h89AB_CDEF;
    issue("ld_word", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h89AB_CDEF, 1'b0, 3);

    issue("st_half_hi", 1'b1, 32'h6, 2'b01, 1'b0, 32'hFFFF_1234, 32'h0, 1'b0, 2);
    check("st_half_hi_addr", obs_waddr, 32'h4);
    check("st_half_hi_strb", 32'(obs_strb), 32'hC);
    check("st_half_hi_data", obs_wdata, 32'h1234_1234);
    issue("st_word", 1'b1, 32'h8, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    check("st_word_addr", obs_waddr, 32'h8);
    check("st_word_strb", 32'(obs_strb), 32'hF);
    check("st_word_data", obs_wdata, 32'hDEAD_BEEF);

    // Stalled memory request, delayed read return, stalled response.
    mem_req_delay = 3;
    rd_delay = 2;
    resp_delay = 2;
    mem_rdata = 32'hCAFE_F00D;
    rd0 = rd_cycles;
    issue("ld_stall", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 8);
    check("ld_stall_read_cycles", 32'(rd_cycles - rd0), 32'd4);
    check("ld_stall_addr", obs_raddr, 32'h40);
    mem_req_delay = 0;
    rd_delay = 0;
    resp_delay = 0;

    // Reset while waiting in RDW: transaction vanishes.
    rd_delay = 1000;
    req_valid = 1'b1;
    req_wen = 1'b0;
    req_addr = 32'h54;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (Read_data_Ready) done = 1'b1;
    end
    if (!done) fail_now("rst_rdw_reach");
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_rdw");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rd_delay = 0;
    @(negedge clk);
    check("rst_rdw_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;

    // Back-to-back with req_valid held: second accept only right after first handshake.
    resp_delay = 1;
    exp_q.push_back(resp_t'{rdata: 32'h0, err: 1'b0});
    exp_q.push_back(resp_t'{rdata: 32'h0, err: 1'b1});
    req_valid = 1'b1;
    req_wen = 1'b1;
    req_addr = 32'h10;
    req_size = 2'b10;
    req_wdata = 32'h1111_1111;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    req_wen = 1'b0;
    req_addr = 32'h12;
    n = 0;
    hs_n = -10;
    acc_n = -1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid && resp_ready) hs_n = n;
      if (req_ready) begin
        acc_n = n;
        done = 1'b1;
      end
    end
    check("b2b_accept_after_hs", 32'(acc_n - hs_n), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) done = 1'b1;
    end
    if (!done) fail_now("b2b_second_resp");
    resp_delay = 0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width on both core and memory sides.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have resetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have req_valid  input  1  core request valid.
REQ-005 SHALL have req_ready  output  1  unit accepts request.
REQ-006 SHALL have req_wen  input  1  1 = store, 0 = load.
REQ-007 SHALL have req_addr  input  ADDR_WIDTH  byte address.
REQ-008 SHALL have req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have req_unsigned  input  1  zero-extend load data when 1.
REQ-010 SHALL have req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have resp_valid / resp_ready  output / input  1 each  response handshake.
REQ-012 SHALL have resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have resp_err  output  1  misaligned or illegal-size request.
REQ-014 SHALL have Address  output  ADDR_WIDTH  word-aligned memory address, bits [1:0] = 0.
REQ-015 SHALL have MemWrite / MemRead  output  1 each  memory write / read request.
REQ-016 SHALL have Write_data  output  32, and Write_strb  output  4  lane-replicated data, byte strobes.
REQ-017 SHALL have Mem_Req_Ready  input  1  memory accepts MemWrite/MemRead.
REQ-018 SHALL have Read_data  input  32, Read_data_Valid  input  1, Read_data_Ready  output  1  read-return handshake.

Function
REQ-019 SHALL implement FSM states IDLE, WREQ, RREQ, RDW, RESP; one request in flight.
REQ-020 SHALL assert req_ready only in IDLE; accept on req_valid & req_ready, registering addr, size, unsigned, wen, wdata.
REQ-021 On accept SHALL go: error -> RESP; store -> WREQ; load -> RREQ.
REQ-022 Error SHALL be: size 11; half with addr[0]=1; word with addr[1:0]!=00; no memory access issued.
REQ-023 In WREQ SHALL hold MemWrite=1 with stable Address/Write_data/Write_strb until Mem_Req_Ready=1, then -> RESP.
REQ-024 In RREQ SHALL hold MemRead=1 with stable Address until Mem_Req_Ready=1, then -> RDW.
REQ-025 In RDW SHALL assert Read_data_Ready=1; on Read_data_Valid=1 capture extracted data, -> RESP.
REQ-026 In RESP SHALL hold resp_valid=1 with stable resp_rdata/resp_err until resp_ready=1, then -> IDLE; no new accept in that cycle.
REQ-027 MemWrite, MemRead, Read_data_Ready SHALL be 0 outside WREQ, RREQ, RDW respectively.
REQ-028 Write_strb: byte = 4'b0001 << addr[1:0]; half = 0011 (addr[1]=0) or 1100 (addr[1]=1); word = 1111; 0 outside WREQ.
REQ-029 Write_data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-030 Load extraction: byte lane addr[1:0], half lane addr[1]; sign-extend from bit 7/15 unless unsigned; word passed unchanged.
REQ-031 Minimum latency accept -> resp_valid: error 1 cycle, store 2 cycles, load 3 cycles (zero-wait memory).
REQ-032 Read_data_Valid outside RDW SHALL be ignored; Mem_Req_Ready outside WREQ/RREQ ignored.

Reset
REQ-033 resetn=0 at posedge SHALL force IDLE and clear all outputs and registered state to 0, except req_ready, which is 0 during reset and 1 in the first cycle after release.
REQ-034 Reset mid-transaction (any state) SHALL abandon it silently: no resp_valid, MemWrite/MemRead drop the next cycle.

Verification
REQ-035 Store byte addr 0x103, wdata 0x000000AB, Mem_Req_Ready=1 -> Address 0x100, Write_strb 1000, Write_data 0xABABABAB, resp_valid 2 cycles after accept, resp_err 0.
REQ-036 Load half signed addr 0x202, Read_data 0x8001_1234 -> resp_rdata 0xFFFF8001; unsigned -> 0x00008001.
REQ-037 Load word addr 0x301 -> resp_err 1, resp_rdata 0, MemRead never asserted, resp_valid 1 cycle after accept.
REQ-038 Load word, Mem_Req_Ready low 3 cycles, Read_data_Valid delayed 2, resp_ready low 2 -> signals held stable, single response 0x(Read_data).
REQ-039 Assert resetn=0 while in RDW -> next cycle all outputs 0, no response; after release req_ready=1.
REQ-040 Back-to-back requests with req_valid held high -> second accepted only in IDLE cycle after first resp handshake.
